// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: receive FSM encoding, frame constants and the
// scan codes the keyboard decoder matches against.
package ps2_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  localparam int unsigned DATA_BITS = 8;
  localparam logic        START_BIT = 1'b0;
  localparam logic        STOP_BIT  = 1'b1;

  localparam logic [7:0] SC_ENTER    = 8'h5A;
  localparam logic [7:0] SC_EXTENDED = 8'hE0;
  localparam logic [7:0] SC_BREAK    = 8'hF0;
  localparam logic [7:0] SC_LEFT     = 8'h6B;
  localparam logic [7:0] SC_RIGHT    = 8'h74;

  // Odd parity: data bits plus parity bit must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [DATA_BITS-1:0] data,
                                         input logic                 par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_sync.sv
// Two-flop synchronizers for PS2_CLK/PS2_DAT plus PS2_CLK falling-edge strobe.
module ps2_sync (
  input  logic CLOCK_50,
  input  logic Reset,
  input  logic ps2_clk_i,
  input  logic ps2_dat_i,
  output logic clk_fall,
  output logic dat_s
);

  logic clk_meta_q, clk_sync_q, clk_prev_q;
  logic dat_meta_q, dat_sync_q;

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      clk_meta_q <= 1'b0;
      clk_sync_q <= 1'b0;
      clk_prev_q <= 1'b0;
      dat_meta_q <= 1'b0;
      dat_sync_q <= 1'b0;
    end else begin
      clk_meta_q <= ps2_clk_i;
      clk_sync_q <= clk_meta_q;
      clk_prev_q <= clk_sync_q;
      dat_meta_q <= ps2_dat_i;
      dat_sync_q <= dat_meta_q;
    end
  end

  // Cleared prev flop means no false edge while the line recovers from reset.
  assign clk_fall = clk_prev_q & ~clk_sync_q;
  assign dat_s    = dat_sync_q;

endmodule

// File: rtl/ps2_rx_framer.sv
// PS/2 receive framer: start, 8 data bits LSB first, odd parity, stop, with a
// frame timeout. Define PS2_PARITY_CHECK_EN to reject frames with bad parity.
module ps2_rx_framer
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       CLOCK_50,
  input  logic       Reset,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] received_data,
  output logic       received_data_en,
  output logic       frame_error
);

  localparam int unsigned CNT_W = $clog2(DATA_BITS);
  localparam int unsigned TMO_W = ($clog2(TIMEOUT_CYCLES) > 0) ? $clog2(TIMEOUT_CYCLES) : 1;
`ifdef PS2_PARITY_CHECK_EN
  localparam logic PARITY_CHECK = 1'b1;
`else
  localparam logic PARITY_CHECK = 1'b0;
`endif

  logic                 clk_fall, dat_s;
  logic [1:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic [7:0]           data_q, data_d;
  logic                 en_q, en_d;
  logic                 err_q, err_d;
  logic                 accept;

  ps2_sync u_sync (
    .CLOCK_50  (CLOCK_50),
    .Reset     (Reset),
    .ps2_clk_i (PS2_CLK),
    .ps2_dat_i (PS2_DAT),
    .clk_fall  (clk_fall),
    .dat_s     (dat_s)
  );

  // Parity is always sampled; it only gates acceptance when checking is built in.
  assign accept = (dat_s == STOP_BIT) &&
                  (odd_parity_ok(shreg_q, par_q) || !PARITY_CHECK);

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      tmo_q   <= '0;
      data_q  <= 8'h00;
      en_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      tmo_q   <= tmo_d;
      data_q  <= data_d;
      en_q    <= en_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    tmo_d   = (state_q == ST_IDLE) ? '0 : tmo_q + TMO_W'(1);
    data_d  = data_q;
    en_d    = 1'b0;
    err_d   = 1'b0;

    if (clk_fall) begin
      tmo_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (dat_s == START_BIT) begin
            state_d = ST_DATA;
            cnt_d   = '0;
          end
        end
        ST_DATA: begin
          shreg_d = {dat_s, shreg_q[DATA_BITS-1:1]};
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_BITS - 1)) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          par_d   = dat_s;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (accept) begin
            data_d = shreg_q;
            en_d   = 1'b1;
          end else begin
            err_d  = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE && tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
      // Keyboard stopped clocking mid-frame: drop it.
      state_d = ST_IDLE;
      tmo_d   = '0;
      err_d   = 1'b1;
    end
  end

  assign received_data    = data_q;
  assign received_data_en = en_q;
  assign frame_error      = err_q;

endmodule

// File: doc/ps2_rx_framer.md
PS2_RX_FRAMER -- requirements
Module: ps2_rx_framer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 50000, SHALL set the number of CLOCK_50 cycles without a PS2_CLK falling edge that aborts a frame (1 ms).
REQ-002 CLOCK_50  input  1  system clock, 50 MHz; all logic SHALL be clocked on its rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 PS2_CLK  input  1  asynchronous PS/2 clock from the keyboard.
REQ-005 PS2_DAT  input  1  asynchronous PS/2 data from the keyboard.
REQ-006 received_data  output  8  last correctly received byte; held until the next good frame.
REQ-007 received_data_en  output  1  one-cycle pulse when received_data is updated.
REQ-008 frame_error  output  1  one-cycle pulse when a frame is discarded.

Function
REQ-009 PS2_CLK and PS2_DAT SHALL each pass through a two-flop synchronizer before use.
REQ-010 A falling edge SHALL be detected when the previous synchronized PS2_CLK is 1 and the current one is 0; all bit sampling SHALL use synchronized PS2_DAT on that cycle.
REQ-011 Frame: start bit 0, 8 data bits LSB first, odd parity bit, stop bit 1 (11 falling edges).
REQ-012 FSM states: IDLE, DATA, PARITY, STOP.
REQ-013 IDLE: on a falling edge with DAT=0, go to DATA with bit counter 0; with DAT=1, stay in IDLE with no error.
REQ-014 DATA: on each falling edge, shift DAT into the shift register MSB and increment the counter; after the 8th bit, go to PARITY.
REQ-015 PARITY: on a falling edge, store DAT as the parity bit and go to STOP.
REQ-016 STOP: on a falling edge with DAT=1 and parity good, register the byte and go to IDLE.
REQ-017 STOP: on a falling edge with DAT=0, pulse frame_error, leave received_data unchanged and go to IDLE.
REQ-018 Parity is good when the 8 data bits plus the parity bit contain an odd number of ones.
REQ-019 received_data and received_data_en SHALL update on the cycle after the stop-bit edge is detected; edge detection to received_data_en is 1 cycle.
REQ-020 Timeout counter SHALL clear on every detected falling edge and count while the FSM is not in IDLE.
REQ-021 When the timeout counter reaches TIMEOUT_CYCLES-1 outside IDLE, the FSM SHALL go to IDLE and pulse frame_error once.
REQ-022 In IDLE, the timeout counter SHALL be held at 0.
REQ-023 received_data_en and frame_error SHALL never assert in the same cycle.
REQ-024 Neither received_data_en nor frame_error SHALL stay high for more than one cycle per frame.

Reset
REQ-025 Reset SHALL force the FSM to IDLE and clear the counters, shift register and synchronizers.
REQ-026 Reset SHALL drive received_data=8'h00, received_data_en=0 and frame_error=0.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame with no pulse on either output.
REQ-028 The first frame starting after Reset deasserts SHALL be received normally.

Configuration
REQ-029 With PS2_PARITY_CHECK_EN defined, a bad-parity frame SHALL pulse frame_error instead of received_data_en and leave received_data unchanged.
REQ-030 With PS2_PARITY_CHECK_EN undefined, the parity bit SHALL be sampled but ignored; only the stop bit gates acceptance.

Structure
REQ-031 Package ps2_pkg SHALL hold the FSM state encoding and the frame constants (DATA_BITS=8, START_BIT=0, STOP_BIT=1).
REQ-032 Package ps2_pkg SHALL also hold the scan-code constants shared with the keyboard decoder (8'h5A, 8'hE0, 8'hF0, 8'h6B, 8'h74).
REQ-033 Sub-module ps2_sync SHALL implement the two synchronizers and falling-edge detection, with outputs clk_fall and dat_s.

Verification
REQ-034 Frame 0x5A, parity 1, stop 1 -> received_data=0x5A, received_data_en high exactly one cycle, frame_error=0.
REQ-035 Frames E0 (parity 0) then 6B (parity 0) back-to-back -> two en pulses, data 0xE0 then 0x6B, no error.
REQ-036 Frame 0x5A with parity 0 -> macro defined: frame_error pulse, received_data keeps its old value; macro undefined: en pulse with 0x5A.
REQ-037 Frame 0x74 with stop bit 0 -> frame_error pulse, no en pulse.
REQ-038 PS2_CLK stops after 4 data bits for TIMEOUT_CYCLES -> one frame_error pulse, FSM in IDLE; a following 0xF0 frame (parity 1) -> en pulse with 0xF0.
REQ-039 Reset pulsed after 5 data bits -> no pulses, received_data=0x00; the next 0x5A frame is received correctly.
